// File: rtl/cmd_decoder.sv
// cmd_decoder: parses a UART byte stream into SYNC/ADDR/DATA/CSUM frames and
// turns each good frame into a one-cycle register-write strobe on the shared
// addr/data/en bus. A bad checksum, a rejected address or an inter-byte
// timeout gives a one-cycle frame_err pulse instead.
// Optional feature macro: CMD_DEC_ADDR_CHECK_EN (reject frames whose address
// exceeds ADDR_MAX). With the macro undefined, the address is truncated and
// written.
module cmd_decoder #(
    parameter int unsigned CLK_MHZ     = 100,
    parameter int unsigned TIMEOUT_US  = 1000,
    parameter int unsigned PAR_MAX_VAL = 255,
    parameter int unsigned ADDR_MAX    = 4,
    parameter logic [7:0]  SYNC_BYTE   = 8'hA5,
    parameter logic [7:0]  CSUM_KEY    = 8'h5A
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [7:0]                         rx_data,
    input  logic                               rx_valid,
    output logic [$clog2(PAR_MAX_VAL+1)-1:0]   data,
    output logic [$clog2(ADDR_MAX+1)-1:0]      addr,
    output logic                               en,
    output logic                               frame_err
);

    localparam int unsigned DATA_W  = $clog2(PAR_MAX_VAL + 1);
    localparam int unsigned ADDR_W  = $clog2(ADDR_MAX + 1);
    localparam int unsigned TMO_CYC = CLK_MHZ * TIMEOUT_US;
    localparam int unsigned TMR_W   = $clog2(TMO_CYC);

    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TMO_CYC - 1);
    localparam logic [7:0]       DATA_MAX = 8'(PAR_MAX_VAL);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_DATA = 2'd2,
        S_CSUM = 2'd3
    } state_e;

    state_e              state_q, state_d;
    logic [7:0]          a_buf_q, a_buf_d;
    logic [7:0]          d_buf_q, d_buf_d;
    logic [TMR_W-1:0]    timer_q, timer_d;
    logic [ADDR_W-1:0]   addr_q,  addr_d;
    logic [DATA_W-1:0]   data_q,  data_d;
    logic                en_q,    en_d;
    logic                ferr_q,  ferr_d;

    logic                csum_ok_c;
    logic                addr_ok_c;
    logic [DATA_W-1:0]   data_clamp_c;

    // Frame qualification: checksum, optional address range, saturating data clamp
    always_comb begin
        csum_ok_c    = (rx_data == (CSUM_KEY ^ a_buf_q ^ d_buf_q));
`ifdef CMD_DEC_ADDR_CHECK_EN
        addr_ok_c    = (a_buf_q <= 8'(ADDR_MAX));
`else
        addr_ok_c    = 1'b1;
`endif
        data_clamp_c = (d_buf_q > DATA_MAX) ? DATA_W'(DATA_MAX) : DATA_W'(d_buf_q);
    end

    // Next-state logic: byte handling takes priority over timeout expiry
    always_comb begin
        state_d = state_q;
        a_buf_d = a_buf_q;
        d_buf_d = d_buf_q;
        timer_d = timer_q;
        addr_d  = addr_q;
        data_d  = data_q;
        en_d    = 1'b0;
        ferr_d  = 1'b0;

        if (rx_valid) begin
            timer_d = '0;
            unique case (state_q)
                S_IDLE: begin
                    if (rx_data == SYNC_BYTE) begin
                        state_d = S_ADDR;
                    end
                end
                S_ADDR: begin
                    a_buf_d = rx_data;
                    state_d = S_DATA;
                end
                S_DATA: begin
                    d_buf_d = rx_data;
                    state_d = S_CSUM;
                end
                S_CSUM: begin
                    state_d = S_IDLE;
                    if (csum_ok_c && addr_ok_c) begin
                        en_d   = 1'b1;
                        addr_d = ADDR_W'(a_buf_q);
                        data_d = data_clamp_c;
                    end else begin
                        ferr_d = 1'b1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end else if (state_q != S_IDLE) begin
            if (timer_q == TMR_LAST) begin
                state_d = S_IDLE;
                ferr_d  = 1'b1;
                timer_d = '0;
            end else begin
                timer_d = timer_q + TMR_W'(1);
            end
        end else begin
            timer_d = '0;
        end
    end

    // State and output registers, synchronous active-high reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            a_buf_q <= '0;
            d_buf_q <= '0;
            timer_q <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            en_q    <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_buf_q <= a_buf_d;
            d_buf_q <= d_buf_d;
            timer_q <= timer_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            en_q    <= en_d;
            ferr_q  <= ferr_d;
        end
    end

    assign data      = data_q;
    assign addr      = addr_q;
    assign en        = en_q;
    assign frame_err = ferr_q;

endmodule

// File: tb/tb_cmd_decoder.sv
// Directed bench for cmd_decoder. Small timeout (50 cycles) and
// PAR_MAX_VAL=200 so clamp and timeout behaviour are reachable quickly.
module tb_cmd_decoder;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] data;
    logic [2:0] addr;
    logic       en;
    logic       frame_err;

    int passed = 0;
    int total  = 0;
    int hit;

    cmd_decoder #(
        .CLK_MHZ     (1),
        .TIMEOUT_US  (50),
        .PAR_MAX_VAL (200),
        .ADDR_MAX    (4),
        .SYNC_BYTE   (8'hA5),
        .CSUM_KEY    (8'h5A)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .data      (data),
        .addr      (addr),
        .en        (en),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Present a byte at a negedge; it is sampled on the following posedge.
    task automatic put(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
    endtask

    task automatic gap();
        rx_valid = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        rst      = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        repeat (2) @(negedge clk);
        chk("rst_en",   32'(en),        32'd0);
        chk("rst_ferr", 32'(frame_err), 32'd0);
        chk("rst_addr", 32'(addr),      32'd0);
        chk("rst_data", 32'(data),      32'd0);
        rst = 1'b0;
        gap();

        // Good frame
        put(8'hA5); put(8'h03); put(8'h80); put(8'hD9);
        chk("t1_en",   32'(en),        32'd1);
        chk("t1_addr", 32'(addr),      32'd3);
        chk("t1_data", 32'(data),      32'h80);
        chk("t1_ferr", 32'(frame_err), 32'd0);
        gap();
        chk("t1_en_pulse", 32'(en), 32'd0);

        // Bad checksum: error pulse, outputs hold
        put(8'hA5); put(8'h02); put(8'h10); put(8'h00);
        chk("t2_ferr", 32'(frame_err), 32'd1);
        chk("t2_en",   32'(en),        32'd0);
        chk("t2_addr", 32'(addr),      32'd3);
        chk("t2_data", 32'(data),      32'h80);
        gap();
        chk("t2_ferr_pulse", 32'(frame_err), 32'd0);

        // Timeout after ADDR byte: error exactly 50 cycles after last byte
        put(8'hA5); put(8'h01);
        hit = 0;
        for (int n = 1; n <= 100 && hit == 0; n++) begin
            gap();
            if (frame_err) hit = n;
        end
        chk("t3_tmo_cycle", 32'(hit), 32'd50);
        chk("t3_tmo_en",    32'(en),  32'd0);
        gap();
        chk("t3_ferr_pulse", 32'(frame_err), 32'd0);
        put(8'hA5); put(8'h01); put(8'h20); put(8'h7B);
        chk("t3_en",   32'(en),   32'd1);
        chk("t3_addr", 32'(addr), 32'd1);
        chk("t3_data", 32'(data), 32'h20);
        gap();

        // Byte arriving on the expiry cycle wins
        put(8'hA5); put(8'h01);
        repeat (49) gap();
        put(8'h20);
        chk("win_noerr", 32'(frame_err), 32'd0);
        put(8'h7B);
        chk("win_en",   32'(en),   32'd1);
        chk("win_data", 32'(data), 32'h20);
        gap();

        // Data clamp at PAR_MAX_VAL=200
        put(8'hA5); put(8'h04); put(8'hFF); put(8'hA1);
        chk("t4_en",   32'(en),   32'd1);
        chk("t4_addr", 32'(addr), 32'd4);
        chk("t4_data", 32'(data), 32'd200);
        gap();
        put(8'hA5); put(8'h02); put(8'hC9); put(8'h91);
        chk("clamp201", 32'(data), 32'd200);
        gap();
        put(8'hA5); put(8'h02); put(8'hC8); put(8'h90);
        chk("clamp200", 32'(data), 32'd200);
        gap();
        put(8'hA5); put(8'h02); put(8'hC7); put(8'h9F);
        chk("clamp199", 32'(data), 32'd199);
        chk("clamp199_addr", 32'(addr), 32'd2);
        gap();

        // Out-of-range address with a correct checksum
        put(8'hA5); put(8'h07); put(8'h11); put(8'h4C);
`ifdef CMD_DEC_ADDR_CHECK_EN
        chk("t5_ferr", 32'(frame_err), 32'd1);
        chk("t5_en",   32'(en),        32'd0);
        chk("t5_addr", 32'(addr),      32'd2);
        chk("t5_data", 32'(data),      32'd199);
`else
        chk("t5_ferr", 32'(frame_err), 32'd0);
        chk("t5_en",   32'(en),        32'd1);
        chk("t5_addr", 32'(addr),      32'd7);
        chk("t5_data", 32'(data),      32'h11);
`endif
        gap();

        // Back-to-back frames with no dead cycle
        put(8'hA5); put(8'h01); put(8'h20); put(8'h7B);
        chk("b2b_en1",   32'(en),   32'd1);
        chk("b2b_addr1", 32'(addr), 32'd1);
        put(8'hA5);
        chk("b2b_gap_en", 32'(en), 32'd0);
        put(8'h03); put(8'h80); put(8'hD9);
        chk("b2b_en2",   32'(en),   32'd1);
        chk("b2b_addr2", 32'(addr), 32'd3);
        chk("b2b_data2", 32'(data), 32'h80);
        gap();

        // Non-sync bytes in IDLE are ignored
        put(8'h12); put(8'h34);
        gap();
        chk("idle_en",   32'(en),        32'd0);
        chk("idle_ferr", 32'(frame_err), 32'd0);

        // Reset mid-frame discards the partial frame
        put(8'hA5); put(8'h03);
        rst      = 1'b1;
        rx_valid = 1'b0;
        @(negedge clk);
        chk("t6_rst_addr", 32'(addr), 32'd0);
        chk("t6_rst_data", 32'(data), 32'd0);
        rst = 1'b0;
        put(8'h80); put(8'hD9);
        chk("t6_en",   32'(en),        32'd0);
        chk("t6_ferr", 32'(frame_err), 32'd0);
        gap();
        chk("t6_en_after", 32'(en),   32'd0);
        chk("t6_addr",     32'(addr), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
